// File: rtl/capture_pkg.sv
// Shared types and helpers for the packet capture DMA controller.
package capture_pkg;

  // Encoding is visible to software through control[1:0].
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DONE    = 2'b10,
    ERROR   = 2'b11
  } cap_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Byte lanes for the final word given remaining bytes mod 4 (0 means a full word).
  function automatic logic [3:0] last_be(input logic [1:0] rem);
    logic [3:0] be;
    unique case (rem)
      2'd1:    be = 4'b0001;
      2'd2:    be = 4'b0011;
      2'd3:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/capture_dma_ctrl.sv
// Packet capture sequencer: streams incoming words into SDRAM through an Avalon-MM write
// master, one outstanding write at a time, and reports progress to the register bank.
module capture_dma_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_start,
  input  logic         cfg_abort,
  input  logic         cfg_clear,
  input  logic [N-1:0] cfg_addr,
  input  logic [N-1:0] cfg_len,
  input  logic         st_valid,
  input  logic [N-1:0] st_data,
  input  logic         st_eop,
  output logic         st_ready,
  output logic [N-1:0] avm_address,
  output logic         avm_write,
  output logic [N-1:0] avm_writedata,
  output logic [3:0]   avm_byteenable,
  input  logic         avm_waitrequest,
  output logic [1:0]   state,
  output logic [N-1:0] words_written,
  output logic         irq
);

  localparam logic [N-1:0] WordBytes = N'(BYTES_PER_WORD);

  cap_state_t   state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] words_q, words_d;
  logic [N-1:0] data_q, data_d;
  logic [3:0]   be_q, be_d;
  logic         write_q, write_d;
  logic         eop_q, eop_d;
  logic         abort_q, abort_d;
  logic         irq_q, irq_d;

  logic         beat_acc;
  logic         commit;
  logic         aborting;
  logic         last_word;

  // Beats are refused while a write is outstanding or once an abort is pending.
  always_comb begin
    st_ready  = (state_q == CAPTURE) && !write_q && !abort_q;
    beat_acc  = st_valid && st_ready;
    commit    = write_q && !avm_waitrequest;
    aborting  = abort_q || cfg_abort;
    last_word = (rem_q <= WordBytes);
  end

  // Next-state and write-port datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    words_d = words_q;
    data_d  = data_q;
    be_d    = be_q;
    write_d = write_q;
    eop_d   = eop_q;
    abort_d = abort_q;
    irq_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Abort in the same cycle as start cancels the start.
        if (cfg_start && !cfg_abort) begin
          if ((cfg_len == '0) || (cfg_addr[1:0] != 2'b00)) begin
            state_d = ERROR;
            irq_d   = 1'b1;
          end else begin
            addr_d  = cfg_addr;
            rem_d   = cfg_len;
            words_d = '0;
            eop_d   = 1'b0;
            abort_d = 1'b0;
            state_d = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        if (cfg_abort) begin
          abort_d = 1'b1;
        end
        if (beat_acc) begin
          write_d = 1'b1;
          data_d  = st_data;
          eop_d   = st_eop;
          be_d    = last_word ? last_be(rem_q[1:0]) : 4'b1111;
        end
        if (commit) begin
          write_d = 1'b0;
          addr_d  = addr_q + WordBytes;
          rem_d   = rem_q - (last_word ? rem_q : WordBytes);
          words_d = words_q + 1'b1;
          // An abort still lets the in-flight write land, but suppresses DONE/irq.
          if (aborting) begin
            state_d = IDLE;
            abort_d = 1'b0;
          end else if (last_word || eop_q) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end
        end else if (!write_q && !beat_acc && aborting) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end
      end

      DONE, ERROR: begin
        if (cfg_clear) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      eop_q   <= 1'b0;
      abort_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      data_q  <= data_d;
      be_q    <= be_d;
      write_q <= write_d;
      eop_q   <= eop_d;
      abort_q <= abort_d;
      irq_q   <= irq_d;
    end
  end

  // Outputs come straight from registers so they stay stable under waitrequest.
  always_comb begin
    avm_address    = addr_q;
    avm_write      = write_q;
    avm_writedata  = data_q;
    avm_byteenable = be_q;
    state          = state_q;
    words_written  = words_q;
    irq            = irq_q;
  end

endmodule

// File: tb/tb_capture_dma_ctrl.sv
// Directed bench for capture_dma_ctrl. Inputs change and outputs are sampled on negedge.
module tb_capture_dma_ctrl;

  logic        clk;
  logic        reset;
  logic        cfg_start, cfg_abort, cfg_clear;
  logic [31:0] cfg_addr, cfg_len;
  logic        st_valid, st_eop, st_ready;
  logic [31:0] st_data;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic [1:0]  state;
  logic [31:0] words_written;
  logic        irq;

  int n_checks;
  int n_fail;

  capture_dma_ctrl #(.N(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_clear       (cfg_clear),
    .cfg_addr        (cfg_addr),
    .cfg_len         (cfg_len),
    .st_valid        (st_valid),
    .st_data         (st_data),
    .st_eop          (st_eop),
    .st_ready        (st_ready),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .state           (state),
    .words_written   (words_written),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: let the posedge happen, land on the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue a start pulse at the current negedge and advance one cycle.
  task automatic start(input logic [31:0] a, input logic [31:0] l);
    cfg_addr  = a;
    cfg_len   = l;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cfg_start = 0; cfg_abort = 0; cfg_clear = 0; cfg_addr = 0; cfg_len = 0;
    st_valid = 0; st_data = 0; st_eop = 0; avm_waitrequest = 0;
    @(negedge clk);
    step();
    n_checks++;
    if ({state, st_ready, avm_write, irq} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: state=%0d ready=%0b write=%0b irq=%0b, need all 0",
               state, st_ready, avm_write, irq);
    end
    n_checks++;
    if ({avm_address, avm_writedata, avm_byteenable, words_written} !== 100'b0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h be=%h words=%0d, need all 0",
               avm_address, avm_writedata, avm_byteenable, words_written);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    start(32'h1000, 32'd8);
    n_checks++;
    if (state !== 2'b01 || st_ready !== 1'b1 || words_written !== 0) begin
      n_fail++;
      $display("FAIL basic_start: state=%0d ready=%0b words=%0d, need 1 1 0",
               state, st_ready, words_written);
    end
    st_valid = 1; st_data = 32'hAAAA_0001;
    step();
    n_checks++;
    if (avm_write !== 1 || avm_address !== 32'h1000 || avm_writedata !== 32'hAAAA_0001 ||
        avm_byteenable !== 4'hF || st_ready !== 0) begin
      n_fail++;
      $display("FAIL basic_w1: wr=%0b addr=%h data=%h be=%h rdy=%0b, need 1 1000 aaaa0001 f 0",
               avm_write, avm_address, avm_writedata, avm_byteenable, st_ready);
    end
    st_data = 32'hBBBB_0002;
    step();
    n_checks++;
    if (avm_write !== 0 || st_ready !== 1 || words_written !== 1) begin
      n_fail++;
      $display("FAIL basic_c1: wr=%0b rdy=%0b words=%0d, need 0 1 1",
               avm_write, st_ready, words_written);
    end
    step();
    st_valid = 0;
    n_checks++;
    if (avm_write !== 1 || avm_address !== 32'h1004 || avm_writedata !== 32'hBBBB_0002 ||
        avm_byteenable !== 4'hF) begin
      n_fail++;
      $display("FAIL basic_w2: wr=%0b addr=%h data=%h be=%h, need 1 1004 bbbb0002 f",
               avm_write, avm_address, avm_writedata, avm_byteenable);
    end
    step();
    n_checks++;
    if (state !== 2'b10 || irq !== 1 || words_written !== 2 || avm_write !== 0 ||
        st_ready !== 0) begin
      n_fail++;
      $display("FAIL basic_done: state=%0d irq=%0b words=%0d wr=%0b rdy=%0b, need 2 1 2 0 0",
               state, irq, words_written, avm_write, st_ready);
    end
    // Start while DONE is ignored.
    start(32'h5000, 32'd4);
    n_checks++;
    if (state !== 2'b10 || irq !== 0 || words_written !== 2) begin
      n_fail++;
      $display("FAIL basic_hold: state=%0d irq=%0b words=%0d, need 2 0 2",
               state, irq, words_written);
    end
    cfg_clear = 1;
    step();
    cfg_clear = 0;
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_clear: state=%0d, need 0", state);
    end
  endtask

  task automatic test_stall();
    start(32'h2000, 32'd6);
    st_valid = 1; st_data = 32'h1111_1111;
    step();
    st_data = 32'h2222_2222;
    step();
    step();
    n_checks++;
    if (avm_write !== 1 || avm_address !== 32'h2004 || avm_writedata !== 32'h2222_2222 ||
        avm_byteenable !== 4'b0011) begin
      n_fail++;
      $display("FAIL stall_w2: wr=%0b addr=%h data=%h be=%b, need 1 2004 22222222 0011",
               avm_write, avm_address, avm_writedata, avm_byteenable);
    end
    avm_waitrequest = 1;
    st_data = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (avm_write !== 1 || avm_address !== 32'h2004 || avm_writedata !== 32'h2222_2222 ||
          avm_byteenable !== 4'b0011 || st_ready !== 0 || state !== 2'b01) begin
        n_fail++;
        $display("FAIL stall_hold%0d: wr=%0b addr=%h data=%h be=%b rdy=%0b st=%0d", i,
                 avm_write, avm_address, avm_writedata, avm_byteenable, st_ready, state);
      end
    end
    avm_waitrequest = 0;
    st_valid = 0;
    step();
    n_checks++;
    if (state !== 2'b10 || irq !== 1 || words_written !== 2) begin
      n_fail++;
      $display("FAIL stall_done: state=%0d irq=%0b words=%0d, need 2 1 2",
               state, irq, words_written);
    end
    step();
    n_checks++;
    if (irq !== 0) begin
      n_fail++;
      $display("FAIL stall_irq_pulse: irq=%0b, need 0", irq);
    end
    cfg_clear = 1;
    step();
    cfg_clear = 0;
  endtask

  task automatic test_eop();
    start(32'h3000, 32'd16);
    st_valid = 1; st_data = 32'hC0DE_0001;
    step();
    st_data = 32'hC0DE_0002; st_eop = 1;
    step();
    step();
    st_valid = 0; st_eop = 0;
    n_checks++;
    if (avm_write !== 1 || avm_address !== 32'h3004 || avm_byteenable !== 4'hF) begin
      n_fail++;
      $display("FAIL eop_w2: wr=%0b addr=%h be=%h, need 1 3004 f",
               avm_write, avm_address, avm_byteenable);
    end
    step();
    n_checks++;
    if (state !== 2'b10 || irq !== 1 || words_written !== 2) begin
      n_fail++;
      $display("FAIL eop_done: state=%0d irq=%0b words=%0d, need 2 1 2",
               state, irq, words_written);
    end
    cfg_clear = 1;
    step();
    cfg_clear = 0;
  endtask

  task automatic test_error();
    start(32'h1002, 32'd8);
    n_checks++;
    if (state !== 2'b11 || irq !== 1 || st_ready !== 0) begin
      n_fail++;
      $display("FAIL err_align: state=%0d irq=%0b rdy=%0b, need 3 1 0", state, irq, st_ready);
    end
    step();
    n_checks++;
    if (state !== 2'b11 || irq !== 0) begin
      n_fail++;
      $display("FAIL err_hold: state=%0d irq=%0b, need 3 0", state, irq);
    end
    cfg_clear = 1;
    step();
    cfg_clear = 0;
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL err_clear: state=%0d, need 0", state);
    end
    start(32'h1000, 32'd0);
    n_checks++;
    if (state !== 2'b11 || irq !== 1) begin
      n_fail++;
      $display("FAIL err_len0: state=%0d irq=%0b, need 3 1", state, irq);
    end
    cfg_clear = 1;
    step();
    cfg_clear = 0;
  endtask

  task automatic test_abort();
    start(32'h4000, 32'd16);
    st_valid = 1; st_data = 32'hDEAD_0001;
    step();
    avm_waitrequest = 1;
    cfg_abort = 1;
    step();
    cfg_abort = 0;
    n_checks++;
    if (avm_write !== 1 || avm_address !== 32'h4000 || st_ready !== 0 || state !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_hold: wr=%0b addr=%h rdy=%0b state=%0d, need 1 4000 0 1",
               avm_write, avm_address, st_ready, state);
    end
    step();
    avm_waitrequest = 0;
    step();
    n_checks++;
    if (state !== 2'b00 || irq !== 0 || words_written !== 1 || avm_write !== 0 ||
        st_ready !== 0) begin
      n_fail++;
      $display("FAIL abort_idle: state=%0d irq=%0b words=%0d wr=%0b rdy=%0b, need 0 0 1 0 0",
               state, irq, words_written, avm_write, st_ready);
    end
    step();
    n_checks++;
    if (irq !== 0 || st_ready !== 0 || avm_write !== 0) begin
      n_fail++;
      $display("FAIL abort_refuse: irq=%0b rdy=%0b wr=%0b, need 0 0 0", irq, st_ready, avm_write);
    end
    st_valid = 0;
  endtask

  task automatic test_wrap();
    start(32'hFFFF_FFFC, 32'd8);
    st_valid = 1; st_data = 32'h0000_00A1;
    step();
    n_checks++;
    if (avm_write !== 1 || avm_address !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_w1: wr=%0b addr=%h, need 1 fffffffc", avm_write, avm_address);
    end
    st_data = 32'h0000_00B2;
    step();
    step();
    st_valid = 0;
    n_checks++;
    if (avm_write !== 1 || avm_address !== 32'h0000_0000 || avm_writedata !== 32'h0000_00B2) begin
      n_fail++;
      $display("FAIL wrap_w2: wr=%0b addr=%h data=%h, need 1 00000000 000000b2",
               avm_write, avm_address, avm_writedata);
    end
    step();
    n_checks++;
    if (state !== 2'b10 || words_written !== 2) begin
      n_fail++;
      $display("FAIL wrap_done: state=%0d words=%0d, need 2 2", state, words_written);
    end
    cfg_clear = 1;
    step();
    cfg_clear = 0;
    cfg_abort = 1;
    start(32'h1000, 32'd8);
    cfg_abort = 0;
    n_checks++;
    if (state !== 2'b00 || irq !== 0) begin
      n_fail++;
      $display("FAIL start_abort: state=%0d irq=%0b, need 0 0", state, irq);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_stall();
    test_eop();
    test_error();
    test_abort();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
